// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: 2-flop synchronizer, 2-of-3 majority vote around the bit centre,
// IDLE/START/DATA/[PARITY]/STOP sequencing. Define UART_RX_PARITY_EN to add an even-parity bit.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);
    localparam int CW       = $clog2(OVERSAMPLE);
    localparam int BW       = $clog2(DATA_BITS + 32'sd1);
    localparam int CENTER_I = OVERSAMPLE / 32'sd2;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_CM1  = CW'(CENTER_I - 32'sd1);
    localparam logic [CW-1:0] CNT_C    = CW'(CENTER_I);
    localparam logic [CW-1:0] CNT_CP1  = CW'(CENTER_I + 32'sd1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 32'sd1);
    localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0] BIT_ONE  = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

`ifdef UART_RX_PARITY_EN
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

    state_t               state_r, state_s;
    logic                 rx_meta_r, rxs_r;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic                 samp_a_r, samp_a_s;
    logic                 samp_b_r, samp_b_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic [BW-1:0]        bit_cnt_r, bit_cnt_s;
    logic [DATA_BITS-1:0] data_out_r, data_out_s;
    logic                 valid_r, valid_s;
    logic                 ferr_r, ferr_s;
    logic                 busy_r;
    logic                 wrap_s, decide_s, decision_s;
`ifdef UART_RX_PARITY_EN
    logic                 par_mis_r, par_mis_s;
    logic                 perr_r, perr_s;
`endif

    // Phase tracking, centre sampling and frame sequencing; nothing moves without baud_en
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        samp_a_s   = samp_a_r;
        samp_b_s   = samp_b_r;
        shift_s    = shift_r;
        bit_cnt_s  = bit_cnt_r;
        data_out_s = data_out_r;
        valid_s    = 1'b0;
        ferr_s     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_mis_s  = par_mis_r;
        perr_s     = 1'b0;
`endif
        wrap_s     = (cnt_r == CNT_LAST);
        decide_s   = (cnt_r == CNT_CP1);
        decision_s = majority3(samp_a_r, samp_b_r, rxs_r);

        if (baud_en) begin
            if (wrap_s) begin
                cnt_s = CNT_ZERO;
            end else begin
                cnt_s = cnt_r + CNT_ONE;
            end
            if (cnt_r == CNT_CM1) begin
                samp_a_s = rxs_r;
            end else begin
                samp_a_s = samp_a_r;
            end
            if (cnt_r == CNT_C) begin
                samp_b_s = rxs_r;
            end else begin
                samp_b_s = samp_b_r;
            end

            case (state_r)
                IDLE: begin
                    // The tick that first sees the low line is phase 0 of the start bit
                    if (!rxs_r) begin
                        state_s   = START;
                        cnt_s     = CNT_ONE;
                        bit_cnt_s = BIT_ZERO;
                    end else begin
                        cnt_s = CNT_ZERO;
                    end
                end
                START: begin
                    if (decide_s && decision_s) begin
                        state_s = IDLE;
                        cnt_s   = CNT_ZERO;
                    end else if (wrap_s) begin
                        state_s = DATA;
                    end else begin
                        state_s = START;
                    end
                end
                DATA: begin
                    if (decide_s) begin
                        shift_s   = {decision_s, shift_r[DATA_BITS-1:1]};
                        bit_cnt_s = bit_cnt_r + BIT_ONE;
                    end else begin
                        shift_s   = shift_r;
                        bit_cnt_s = bit_cnt_r;
                    end
                    if (wrap_s && (bit_cnt_r == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
                        state_s = PARITY;
`else
                        state_s = STOP;
`endif
                    end else begin
                        state_s = DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (decide_s) begin
                        par_mis_s = decision_s ^ even_parity(shift_r);
                    end else begin
                        par_mis_s = par_mis_r;
                    end
                    if (wrap_s) begin
                        state_s = STOP;
                    end else begin
                        state_s = PARITY;
                    end
                end
`endif
                STOP: begin
                    // Leave at the decision point so a start bit right after the stop bit is caught
                    if (decide_s) begin
                        state_s    = IDLE;
                        cnt_s      = CNT_ZERO;
                        data_out_s = shift_r;
                        valid_s    = 1'b1;
                        ferr_s     = ~decision_s;
`ifdef UART_RX_PARITY_EN
                        perr_s     = par_mis_r;
`endif
                    end else begin
                        state_s = STOP;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Two-flop synchronizer on the raw line, idle high out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rxs_r     <= rx_meta_r;
        end
    end

    // FSM, datapath and registered one-clock result pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            samp_a_r   <= 1'b1;
            samp_b_r   <= 1'b1;
            shift_r    <= {DATA_BITS{1'b0}};
            bit_cnt_r  <= BIT_ZERO;
            data_out_r <= {DATA_BITS{1'b0}};
            valid_r    <= 1'b0;
            ferr_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            samp_a_r   <= samp_a_s;
            samp_b_r   <= samp_b_s;
            shift_r    <= shift_s;
            bit_cnt_r  <= bit_cnt_s;
            data_out_r <= data_out_s;
            valid_r    <= valid_s;
            ferr_r     <= ferr_s;
            busy_r     <= (state_s != IDLE);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mismatch latch and its result pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_mis_r <= 1'b0;
            perr_r    <= 1'b0;
        end else begin
            par_mis_r <= par_mis_s;
            perr_r    <= perr_s;
        end
    end

    assign parity_err = perr_r;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out   = data_out_r;
    assign data_valid = valid_r;
    assign frame_err  = ferr_r;
    assign busy       = busy_r;
endmodule
